// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern generator (rotate-left/right, bounce, binary) plus heartbeat blink.
// Latency: LEDS/HEARTBEAT are combinational views of registered state; ADV is registered (pulses with the new pattern).
// Backpressure: none; PAUSE freezes the prescaler and the pattern, STEP forces one advance regardless of PAUSE.
// Ports: CLK, RST_N (async assert, sync release), MODE[1:0], PAUSE, STEP in; LEDS[N_LEDS-1:0], HEARTBEAT, ADV out.
module led_sequencer #(
  parameter int N_LEDS       = 8,
  parameter int PRESCALE_MAX = 16777215,
  parameter int ACTIVE_LOW   = 1,
  parameter int HB_BIT       = 23
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        MODE,
  input  logic              PAUSE,
  input  logic              STEP,
  output logic [N_LEDS-1:0] LEDS,
  output logic              HEARTBEAT,
  output logic              ADV
);

  localparam int PW = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE_MAX);

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [N_LEDS-1:0] PAT_LSB = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] PAT_MSB = {1'b1, {(N_LEDS-1){1'b0}}};

  // Reset: asserts immediately, releases two CLK edges after RST_N rises.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  // State
  logic [N_LEDS-1:0] pat, pat_nxt;
  logic              dir, dir_nxt;
  logic [1:0]        mode_q;
  logic [PW-1:0]     presc, presc_nxt;
  logic [31:0]       hb;
  logic              adv_q, adv_nxt;

  logic mode_chg;
  logic tick;
  logic adv;

  // State register
  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      pat    <= PAT_LSB;
      dir    <= DIR_LEFT;
      mode_q <= MODE_ROL;
      presc  <= '0;
      hb     <= '0;
      adv_q  <= 1'b0;
    end else begin
      pat    <= pat_nxt;
      dir    <= dir_nxt;
      mode_q <= MODE;
      presc  <= presc_nxt;
      hb     <= hb + 32'd1;
      adv_q  <= adv_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    mode_chg  = (MODE != mode_q);
    // Gate tick with PAUSE: a prescaler frozen at its top value must not keep firing.
    tick      = !PAUSE && (presc == PRESC_TOP);
    adv       = tick | STEP;
    pat_nxt   = pat;
    dir_nxt   = dir;
    presc_nxt = presc;
    adv_nxt   = 1'b0;

    if (mode_chg)   presc_nxt = '0;
    else if (!PAUSE) presc_nxt = (presc == PRESC_TOP) ? '0 : presc + 1'b1;

    if (mode_chg) begin
      // A mode switch restarts the pattern and swallows any coincident advance.
      dir_nxt = DIR_LEFT;
      case (MODE)
        MODE_ROL:    pat_nxt = PAT_LSB;
        MODE_ROR:    pat_nxt = PAT_MSB;
        MODE_BOUNCE: pat_nxt = PAT_LSB;
        default:     pat_nxt = '0;
      endcase
    end else if (adv) begin
      adv_nxt = 1'b1;
      case (mode_q)
        MODE_ROL: pat_nxt = {pat[N_LEDS-2:0], pat[N_LEDS-1]};
        MODE_ROR: pat_nxt = {pat[0], pat[N_LEDS-1:1]};
        MODE_BOUNCE: begin
          // Direction flips on the step that lands on an end, so each end shows for one step.
          if (dir == DIR_LEFT) begin
            pat_nxt = pat << 1;
            if (pat[N_LEDS-2]) dir_nxt = DIR_RIGHT;
          end else begin
            pat_nxt = pat >> 1;
            if (pat[1]) dir_nxt = DIR_LEFT;
          end
        end
        default: pat_nxt = pat + 1'b1;
      endcase
    end
  end

  // Outputs at pin polarity
  always_comb begin
    LEDS      = (ACTIVE_LOW != 0) ? ~pat : pat;
    HEARTBEAT = (ACTIVE_LOW != 0) ? ~hb[HB_BIT] : hb[HB_BIT];
    ADV       = adv_q;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench for led_sequencer (N_LEDS=8, PRESCALE_MAX=3, ACTIVE_LOW=1, HB_BIT=2).
// Expected LEDS values are queued as stimulus is applied and popped on each ADV pulse.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_led_sequencer;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] MODE  = 2'd0;
  logic       PAUSE = 1'b0;
  logic       STEP  = 1'b0;
  logic [7:0] LEDS;
  logic       HEARTBEAT;
  logic       ADV;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  led_sequencer #(
    .N_LEDS(8), .PRESCALE_MAX(3), .ACTIVE_LOW(1), .HB_BIT(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .PAUSE(PAUSE), .STEP(STEP),
    .LEDS(LEDS), .HEARTBEAT(HEARTBEAT), .ADV(ADV)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    RST_N = 1'b0; MODE = 2'd0; PAUSE = 1'b0; STEP = 1'b0;
    #12;
    n_cmp++; if (LEDS !== 8'hFE) begin n_bad++; $display("FAIL reset_leds: got %h want fe", LEDS); end
    n_cmp++; if (HEARTBEAT !== 1'b1) begin n_bad++; $display("FAIL reset_hb: got %b want 1", HEARTBEAT); end
    n_cmp++; if (ADV !== 1'b0) begin n_bad++; $display("FAIL reset_adv: got %b want 0", ADV); end
    @(negedge CLK); RST_N = 1'b1;
    // Two sync edges plus three counting edges before the first tick.
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      n_cmp++; if (LEDS !== 8'hFE || ADV !== 1'b0) begin
        n_bad++; $display("FAIL reset_hold c=%0d: leds=%h adv=%b want fe/0", c, LEDS, ADV);
      end
    end
  endtask

  task automatic test_rotate_left();
    logic [7:0] e;
    int last = -1;
    logic [7:0] tbl [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge CLK);
      if (ADV) begin
        e = exp_q.pop_front();
        n_cmp++; if (LEDS !== e) begin n_bad++; $display("FAIL rol_leds: got %h want %h", LEDS, e); end
        if (last >= 0) begin
          n_cmp++; if (c - last != 4) begin n_bad++; $display("FAIL rol_period: got %0d want 4", c - last); end
        end
        last = c;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rol_timeout: %0d steps missing, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_rotate_right();
    logic [7:0] e;
    logic [7:0] tbl [8] = '{8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'h7F};
    MODE = 2'd1;
    @(negedge CLK);
    n_cmp++; if (LEDS !== 8'h7F || ADV !== 1'b0) begin
      n_bad++; $display("FAIL ror_init: leds=%h adv=%b want 7f/0", LEDS, ADV);
    end
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      @(negedge CLK);
      if (ADV) begin
        e = exp_q.pop_front();
        n_cmp++; if (LEDS !== e) begin n_bad++; $display("FAIL ror_leds: got %h want %h", LEDS, e); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL ror_timeout: %0d steps missing, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_bounce();
    logic [7:0] e;
    logic [31:0] hbv;
    logic [7:0] tbl [22] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04,
                             8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
    @(negedge CLK); RST_N = 1'b0; MODE = 2'd2;
    @(negedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    foreach (tbl[i]) exp_q.push_back(~tbl[i]);
    for (int c = 0; c < 110 && exp_q.size() > 0; c++) begin
      @(negedge CLK);
      if (ADV) begin
        e = exp_q.pop_front();
        n_cmp++; if (LEDS !== e) begin n_bad++; $display("FAIL bounce_leds: got %h want %h", LEDS, e); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bounce_timeout: %0d steps missing, want 0", exp_q.size()); end
    exp_q.delete();
    n_cmp++; if (dut.dir !== 1'b1) begin n_bad++; $display("FAIL bounce_dir: got %b want 1", dut.dir); end
    // Mid-cycle reset: pattern and direction must drop before the next edge.
    #2 RST_N = 1'b0;
    #1;
    n_cmp++; if (LEDS !== 8'hFE) begin n_bad++; $display("FAIL midrst_leds: got %h want fe", LEDS); end
    n_cmp++; if (dut.dir !== 1'b0) begin n_bad++; $display("FAIL midrst_dir: got %b want 0", dut.dir); end
    n_cmp++; if (HEARTBEAT !== 1'b1 || ADV !== 1'b0) begin
      n_bad++; $display("FAIL midrst_out: hb=%b adv=%b want 1/0", HEARTBEAT, ADV);
    end
    @(negedge CLK); RST_N = 1'b1;
    // Counter starts on the third edge after release (two sync flops).
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      hbv = (k >= 2) ? 32'(k - 2) : 32'd0;
      n_cmp++; if (HEARTBEAT !== ~hbv[2]) begin
        n_bad++; $display("FAIL heartbeat k=%0d: got %b want %b", k, HEARTBEAT, ~hbv[2]);
      end
    end
  endtask

  task automatic test_binary();
    logic [7:0] e;
    int n_adv = 0;
    MODE = 2'd3;
    @(negedge CLK);
    n_cmp++; if (LEDS !== 8'hFF || ADV !== 1'b0) begin
      n_bad++; $display("FAIL bin_init: leds=%h adv=%b want ff/0", LEDS, ADV);
    end
    for (int i = 1; i <= 256; i++) exp_q.push_back(~8'(i));
    for (int c = 0; c < 1100 && exp_q.size() > 0; c++) begin
      @(negedge CLK);
      if (ADV) begin
        n_adv++;
        e = exp_q.pop_front();
        n_cmp++; if (LEDS !== e) begin n_bad++; $display("FAIL bin_leds step %0d: got %h want %h", n_adv, LEDS, e); end
      end
    end
    n_cmp++; if (n_adv != 256) begin n_bad++; $display("FAIL bin_count: got %0d want 256", n_adv); end
    exp_q.delete();
  endtask

  task automatic test_pause_step();
    logic [7:0] e;
    int n_adv = 0;
    // One edge after the wrap the prescaler holds 1.
    @(negedge CLK);
    PAUSE = 1'b1;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFD); exp_q.push_back(8'hFC);
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (ADV) begin
        n_adv++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL pause_extra_adv: got leds=%h want no advance", LEDS);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (LEDS !== e) begin n_bad++; $display("FAIL pause_leds: got %h want %h", LEDS, e); end
        end
      end
      STEP = (c == 2 || c == 7 || c == 13);
    end
    n_cmp++; if (n_adv != 3) begin n_bad++; $display("FAIL pause_count: got %0d want 3", n_adv); end
    PAUSE = 1'b0;
    n_cmp++; if (dut.presc !== 2'd1) begin n_bad++; $display("FAIL pause_presc: got %0d want 1", dut.presc); end
    exp_q.delete();
  endtask

  task automatic test_coincident();
    logic [7:0] e;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++; if (dut.presc !== 2'd3) begin n_bad++; $display("FAIL coin_presc: got %0d want 3", dut.presc); end
    STEP = 1'b1;
    exp_q.push_back(8'hFB);
    @(negedge CLK);
    STEP = 1'b0;
    n_cmp++; if (ADV !== 1'b1) begin n_bad++; $display("FAIL coin_adv: got %b want 1", ADV); end
    if (ADV && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (LEDS !== e) begin n_bad++; $display("FAIL coin_leds: got %h want %h", LEDS, e); end
    end
    @(negedge CLK);
    n_cmp++; if (ADV !== 1'b0 || LEDS !== 8'hFB) begin
      n_bad++; $display("FAIL coin_single: adv=%b leds=%h want 0/fb", ADV, LEDS);
    end
    exp_q.delete();
    MODE = 2'd0;
    @(negedge CLK);
    n_cmp++; if (LEDS !== 8'hFE || dut.presc !== 2'd0) begin
      n_bad++; $display("FAIL chg0_init: leds=%h presc=%0d want fe/0", LEDS, dut.presc);
    end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (ADV !== 1'b0) begin n_bad++; $display("FAIL chg0_adv c=%0d: got %b want 0", c, ADV); end
      @(negedge CLK);
    end
    n_cmp++; if (dut.presc !== 2'd3) begin n_bad++; $display("FAIL chg_tick_presc: got %0d want 3", dut.presc); end
    MODE = 2'd1;
    @(negedge CLK);
    n_cmp++; if (LEDS !== 8'h7F) begin n_bad++; $display("FAIL chg_tick_leds: got %h want 7f", LEDS); end
    n_cmp++; if (ADV !== 1'b0) begin n_bad++; $display("FAIL chg_tick_adv: got %b want 0", ADV); end
    n_cmp++; if (dut.presc !== 2'd0) begin n_bad++; $display("FAIL chg_tick_presc0: got %0d want 0", dut.presc); end
  endtask

  initial begin
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_bounce();
    test_binary();
    test_pause_step();
    test_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
